pe_pad_loader: RTL and testbench
================================

Name: pe_pad_loader

Overview:
Sequences the loading of a PE's input pad (IPAD) and weight pad (WPAD) from the upstream Input and Weight rdyack streams. A load job is accepted via a Conf rdyack handshake carrying per-pad word counts and start addresses. The block generates RF_2P write enables and addresses with wrap-around, and signals completion to the DataPathController through a Load rdyack handshake. It sits between the global-buffer streams and the pad write ports, upstream of compute sequencing.

Parameters:
IPADSIZE, 12, IPAD depth in words
WPADSIZE, 24, WPAD depth in words
IAW, $clog2(IPADSIZE), IPAD address width
WAW, $clog2(WPADSIZE), WPAD address width
ILW, $clog2(IPADSIZE+1), IPAD length field width
WLW, $clog2(WPADSIZE+1), WPAD length field width

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
Conf_rdy  in  1  load job valid
Conf_ack  out  1  load job accepted
i_ilen  in  ILW  input words to load (0 = skip IPAD)
i_wlen  in  WLW  weight words to load (0 = skip WPAD)
i_ibase  in  IAW  IPAD start address
i_wbase  in  WAW  WPAD start address
Input_rdy  in  1  input word valid
Input_ack  out  1  input word accepted
Weight_rdy  in  1  weight word valid
Weight_ack  out  1  weight word accepted
o_ip_write  out  1  IPAD write enable
o_ip_waddr  out  IAW  IPAD write address
o_wp_write  out  1  WPAD write enable
o_wp_waddr  out  WAW  WPAD write address
Load_rdy  out  1  job complete, pads valid
Load_ack  in  1  completion consumed
o_busy  out  1  state != IDLE

Behaviour:
- Transfer on any rdyack pair = rdy && ack in the same cycle. Acks are combinational from state and counters only, never from the corresponding rdy.
- States: IDLE, LOAD, DONE. Reset: state=IDLE, counters and addresses 0. Reset forces all outputs to 0 (Conf_ack follows IDLE to 1 after reset release). Reset mid-job discards the job with no further writes.
- IDLE: Conf_ack=1. On Conf transfer, latch the job fields and go to LOAD. Lengths are clamped to pad size (i_ilen>IPADSIZE becomes IPADSIZE; same for WPAD). Base addresses >= size are reduced modulo size. If both clamped lengths are 0, go directly to DONE.
- LOAD:
  - Input_ack = (icnt < ilen). Weight_ack = (wcnt < wlen). The two streams are independent and may both transfer in one cycle.
  - o_ip_write = Input_rdy && Input_ack (combinational, same cycle). o_ip_waddr = current iaddr.
  - On an input transfer, icnt+1 and iaddr+1, with iaddr wrapping from IPADSIZE-1 to 0. The weight side behaves the same way with WPADSIZE.
  - Go to DONE in the cycle after the last outstanding transfer, i.e. when icnt==ilen && wcnt==wlen is registered.
- DONE: Load_rdy=1, held until Load_ack. Acks to Input, Weight and Conf are 0. On Load_ack, go to IDLE and clear the counters.
- No back-to-back Conf acceptance in the Load_ack cycle; Conf_ack rises the following cycle.
- Total latency: Conf transfer to Load_rdy = max(ilen, wlen) stream-limited cycles + 1. With both lengths 0, Load_rdy rises 1 cycle after Conf.
- o_ip_waddr/o_wp_waddr hold their last value when not writing. o_busy=1 in LOAD and DONE.

Test Plan:
- Reset, then Conf{ilen=3, wlen=5, ibase=0, wbase=0}, both streams always rdy -> ip writes at addr 0,1,2 and wp writes at addr 0..4 starting the cycle after Conf. Load_rdy at cycle 6 after Conf. Acks drop exactly after 3 and 5 transfers.
- Conf{ilen=4, ibase=10, wlen=0}, IPADSIZE=12 -> writes to addr 10,11,0,1. Weight_ack stays 0 throughout.
- Conf{ilen=20, wlen=30} -> clamped: exactly 12 input and 24 weight transfers, then DONE.
- Conf{ilen=0, wlen=0} -> Load_rdy=1 one cycle after Conf. No writes occur.
- Random rdy gaps (50% duty) on both streams with Load_ack withheld 5 cycles -> no writes during gaps, Load_rdy stays high until ack, and Conf_ack returns 1 the cycle after Load_ack.
- Assert i_rst after 2 of 5 weight writes -> next cycle all outputs 0 and state IDLE. A new Conf restarts at wbase.

Source files
------------

// File: rtl/pe_pad_loader.sv
// Sequences IPAD/WPAD fills from the Input/Weight rdyack streams for one Conf job, then holds Load_rdy.
// Write enables are combinational with the stream transfer; Load_rdy rises max(ilen,wlen)+1 cycles after Conf.
module pe_pad_loader #(
  parameter int IPADSIZE = 12,
  parameter int WPADSIZE = 24,
  parameter int IAW      = $clog2(IPADSIZE),
  parameter int WAW      = $clog2(WPADSIZE),
  parameter int ILW      = $clog2(IPADSIZE + 1),
  parameter int WLW      = $clog2(WPADSIZE + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           Conf_rdy,
  output logic           Conf_ack,
  input  logic [ILW-1:0] i_ilen,
  input  logic [WLW-1:0] i_wlen,
  input  logic [IAW-1:0] i_ibase,
  input  logic [WAW-1:0] i_wbase,
  input  logic           Input_rdy,
  output logic           Input_ack,
  input  logic           Weight_rdy,
  output logic           Weight_ack,
  output logic           o_ip_write,
  output logic [IAW-1:0] o_ip_waddr,
  output logic           o_wp_write,
  output logic [WAW-1:0] o_wp_waddr,
  output logic           Load_rdy,
  input  logic           Load_ack,
  output logic           o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [ILW-1:0] ILEN_MAX   = ILW'(IPADSIZE);
  localparam logic [WLW-1:0] WLEN_MAX   = WLW'(WPADSIZE);
  localparam logic [IAW-1:0] IADDR_LAST = IAW'(IPADSIZE - 1);
  localparam logic [WAW-1:0] WADDR_LAST = WAW'(WPADSIZE - 1);
  localparam logic [IAW-1:0] IADDR_SIZE = IAW'(IPADSIZE);
  localparam logic [WAW-1:0] WADDR_SIZE = WAW'(WPADSIZE);

  state_e         state_q, state_d;
  logic [ILW-1:0] ilen_q, ilen_d;
  logic [WLW-1:0] wlen_q, wlen_d;
  logic [ILW-1:0] icnt_q, icnt_d;
  logic [WLW-1:0] wcnt_q, wcnt_d;
  logic [IAW-1:0] iaddr_q, iaddr_d;
  logic [WAW-1:0] waddr_q, waddr_d;

  logic           conf_ack_c;
  logic           in_ack_c;
  logic           wt_ack_c;
  logic           load_rdy_c;
  logic           in_xfer_c;
  logic           wt_xfer_c;
  logic [ILW-1:0] ilen_clamp_c;
  logic [WLW-1:0] wlen_clamp_c;
  logic [IAW-1:0] ibase_mod_c;
  logic [WAW-1:0] wbase_mod_c;

  // A base at or above the pad size needs only one subtraction: 2^AW < 2*SIZE.
  always_comb begin
    ilen_clamp_c = (int'(i_ilen) > IPADSIZE) ? ILEN_MAX : i_ilen;
    wlen_clamp_c = (int'(i_wlen) > WPADSIZE) ? WLEN_MAX : i_wlen;
    ibase_mod_c  = (int'(i_ibase) >= IPADSIZE) ? (i_ibase - IADDR_SIZE) : i_ibase;
    wbase_mod_c  = (int'(i_wbase) >= WPADSIZE) ? (i_wbase - WADDR_SIZE) : i_wbase;
  end

  always_comb begin
    state_d    = state_q;
    ilen_d     = ilen_q;
    wlen_d     = wlen_q;
    icnt_d     = icnt_q;
    wcnt_d     = wcnt_q;
    iaddr_d    = iaddr_q;
    waddr_d    = waddr_q;
    conf_ack_c = 1'b0;
    in_ack_c   = 1'b0;
    wt_ack_c   = 1'b0;
    load_rdy_c = 1'b0;
    in_xfer_c  = 1'b0;
    wt_xfer_c  = 1'b0;

    case (state_q)
      IDLE: begin
        conf_ack_c = 1'b1;
        if (Conf_rdy) begin
          ilen_d  = ilen_clamp_c;
          wlen_d  = wlen_clamp_c;
          iaddr_d = ibase_mod_c;
          waddr_d = wbase_mod_c;
          icnt_d  = '0;
          wcnt_d  = '0;
          if (ilen_clamp_c == '0 && wlen_clamp_c == '0) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        in_ack_c  = (icnt_q < ilen_q);
        wt_ack_c  = (wcnt_q < wlen_q);
        in_xfer_c = Input_rdy && in_ack_c;
        wt_xfer_c = Weight_rdy && wt_ack_c;
        if (in_xfer_c) begin
          icnt_d  = icnt_q + ILW'(1);
          iaddr_d = (iaddr_q == IADDR_LAST) ? '0 : iaddr_q + IAW'(1);
        end
        if (wt_xfer_c) begin
          wcnt_d  = wcnt_q + WLW'(1);
          waddr_d = (waddr_q == WADDR_LAST) ? '0 : waddr_q + WAW'(1);
        end
        // Leave on the edge of the final transfer so DONE shows up the next cycle.
        if (icnt_d == ilen_q && wcnt_d == wlen_q) begin
          state_d = DONE;
        end
      end

      DONE: begin
        load_rdy_c = 1'b1;
        if (Load_ack) begin
          state_d = IDLE;
          icnt_d  = '0;
          wcnt_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ilen_q  <= '0;
      wlen_q  <= '0;
      icnt_q  <= '0;
      wcnt_q  <= '0;
      iaddr_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      ilen_q  <= ilen_d;
      wlen_q  <= wlen_d;
      icnt_q  <= icnt_d;
      wcnt_q  <= wcnt_d;
      iaddr_q <= iaddr_d;
      waddr_q <= waddr_d;
    end
  end

  // Outputs are forced low for as long as reset is held, even before the state register clears.
  always_comb begin
    Conf_ack   = conf_ack_c && !i_rst;
    Input_ack  = in_ack_c && !i_rst;
    Weight_ack = wt_ack_c && !i_rst;
    o_ip_write = in_xfer_c && !i_rst;
    o_wp_write = wt_xfer_c && !i_rst;
    Load_rdy   = load_rdy_c && !i_rst;
    o_busy     = (state_q != IDLE) && !i_rst;
    o_ip_waddr = i_rst ? '0 : iaddr_q;
    o_wp_waddr = i_rst ? '0 : waddr_q;
  end

endmodule

// File: tb/tb_pe_pad_loader.sv
// Directed bench for pe_pad_loader: per-cycle checks of acks, write strobes/addresses and Load timing.
// Expected values come from hand-computed job parameters tracked by a tiny in-bench counter model.
module tb_pe_pad_loader;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       Conf_rdy;
  logic       Conf_ack;
  logic [3:0] i_ilen;
  logic [4:0] i_wlen;
  logic [3:0] i_ibase;
  logic [4:0] i_wbase;
  logic       Input_rdy;
  logic       Input_ack;
  logic       Weight_rdy;
  logic       Weight_ack;
  logic       o_ip_write;
  logic [3:0] o_ip_waddr;
  logic       o_wp_write;
  logic [4:0] o_wp_waddr;
  logic       Load_rdy;
  logic       Load_ack;
  logic       o_busy;

  int errors = 0;
  int checks = 0;

  pe_pad_loader dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .Conf_rdy   (Conf_rdy),
    .Conf_ack   (Conf_ack),
    .i_ilen     (i_ilen),
    .i_wlen     (i_wlen),
    .i_ibase    (i_ibase),
    .i_wbase    (i_wbase),
    .Input_rdy  (Input_rdy),
    .Input_ack  (Input_ack),
    .Weight_rdy (Weight_rdy),
    .Weight_ack (Weight_ack),
    .o_ip_write (o_ip_write),
    .o_ip_waddr (o_ip_waddr),
    .o_wp_write (o_wp_write),
    .o_wp_waddr (o_wp_waddr),
    .Load_rdy   (Load_rdy),
    .Load_ack   (Load_ack),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One Conf job: cycle 0 is the Conf transfer, then per-cycle checks until DONE,
  // Load_ack withheld for ack_wait cycles, then the IDLE return.
  task automatic run_job(input string name, input int il, input int wl, input int ib,
                         input int wb, input bit gaps, input int ack_wait);
    int eil, ewl, ea_i, ea_w, ic, wc, cyc;
    bit irdy, wrdy, done;
    eil  = (il > 12) ? 12 : il;
    ewl  = (wl > 24) ? 24 : wl;
    ea_i = ib % 12;
    ea_w = wb % 24;
    ic   = 0;
    wc   = 0;
    @(negedge i_clk);
    Conf_rdy   = 1'b1;
    i_ilen     = 4'(il);
    i_wlen     = 5'(wl);
    i_ibase    = 4'(ib);
    i_wbase    = 5'(wb);
    Input_rdy  = 1'b0;
    Weight_rdy = 1'b0;
    #1;
    chk({name, ".conf_ack"}, Conf_ack, 1);
    chk({name, ".idle_busy"}, o_busy, 0);
    @(negedge i_clk);
    Conf_rdy = 1'b0;
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 300) begin
      irdy = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wrdy = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      Input_rdy  = irdy;
      Weight_rdy = wrdy;
      #1;
      if (ic == eil && wc == ewl) begin
        chk({name, ".load_rdy"}, Load_rdy, 1);
        chk({name, ".done_iack"}, Input_ack, 0);
        chk({name, ".done_wack"}, Weight_ack, 0);
        chk({name, ".done_conf_ack"}, Conf_ack, 0);
        chk({name, ".done_busy"}, o_busy, 1);
        if (!gaps) chk({name, ".latency"}, cyc, ((eil > ewl) ? eil : ewl) + 1);
        done = 1'b1;
      end else begin
        chk({name, ".load_rdy_low"}, Load_rdy, 0);
        chk({name, ".iack"}, Input_ack, (ic < eil));
        chk({name, ".wack"}, Weight_ack, (wc < ewl));
        chk({name, ".ip_write"}, o_ip_write, (irdy && ic < eil));
        chk({name, ".wp_write"}, o_wp_write, (wrdy && wc < ewl));
        if (irdy && ic < eil) begin
          chk({name, ".ip_waddr"}, o_ip_waddr, ea_i);
          ic++;
          ea_i = (ea_i + 1) % 12;
        end
        if (wrdy && wc < ewl) begin
          chk({name, ".wp_waddr"}, o_wp_waddr, ea_w);
          wc++;
          ea_w = (ea_w + 1) % 24;
        end
        @(negedge i_clk);
        cyc++;
      end
    end
    if (!done) chk({name, ".reached_done"}, 0, 1);
    for (int k = 0; k < ack_wait; k++) begin
      @(negedge i_clk);
      Input_rdy  = 1'b1;
      Weight_rdy = 1'b1;
      #1;
      chk({name, ".load_rdy_held"}, Load_rdy, 1);
      chk({name, ".held_ip_write"}, o_ip_write, 0);
      chk({name, ".held_wp_write"}, o_wp_write, 0);
    end
    @(negedge i_clk);
    Load_ack = 1'b1;
    #1;
    chk({name, ".ack_cycle_load_rdy"}, Load_rdy, 1);
    chk({name, ".ack_cycle_conf_ack"}, Conf_ack, 0);
    @(negedge i_clk);
    Load_ack   = 1'b0;
    Input_rdy  = 1'b0;
    Weight_rdy = 1'b0;
    #1;
    chk({name, ".conf_ack_back"}, Conf_ack, 1);
    chk({name, ".load_rdy_clear"}, Load_rdy, 0);
    chk({name, ".busy_clear"}, o_busy, 0);
  endtask

  initial begin
    i_rst      = 1'b1;
    Conf_rdy   = 1'b0;
    i_ilen     = '0;
    i_wlen     = '0;
    i_ibase    = '0;
    i_wbase    = '0;
    Input_rdy  = 1'b0;
    Weight_rdy = 1'b0;
    Load_ack   = 1'b0;

    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    chk("rst.conf_ack", Conf_ack, 0);
    chk("rst.busy", o_busy, 0);
    chk("rst.load_rdy", Load_rdy, 0);
    chk("rst.ip_waddr", o_ip_waddr, 0);
    chk("rst.wp_waddr", o_wp_waddr, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("post_rst.conf_ack", Conf_ack, 1);
    chk("post_rst.iack", Input_ack, 0);

    run_job("basic", 3, 5, 0, 0, 1'b0, 0);
    run_job("iwrap", 4, 0, 10, 0, 1'b0, 0);
    // Max encodable lengths (15, 31) clamp to 12/24; bases 14, 30 reduce to 2, 6.
    run_job("clamp", 15, 31, 14, 30, 1'b0, 1);
    run_job("zero", 0, 0, 3, 3, 1'b0, 0);
    run_job("gaps", 7, 9, 5, 20, 1'b1, 5);

    // Reset after two of five weight writes.
    @(negedge i_clk);
    Conf_rdy = 1'b1;
    i_ilen   = 4'd0;
    i_wlen   = 5'd5;
    i_ibase  = 4'd0;
    i_wbase  = 5'd3;
    #1;
    chk("rstjob.conf_ack", Conf_ack, 1);
    @(negedge i_clk);
    Conf_rdy   = 1'b0;
    Weight_rdy = 1'b1;
    #1;
    chk("rstjob.wr0", o_wp_write, 1);
    chk("rstjob.addr0", o_wp_waddr, 3);
    @(negedge i_clk);
    #1;
    chk("rstjob.wr1", o_wp_write, 1);
    chk("rstjob.addr1", o_wp_waddr, 4);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("rstjob.held_wr", o_wp_write, 0);
    chk("rstjob.held_wack", Weight_ack, 0);
    chk("rstjob.held_busy", o_busy, 0);
    chk("rstjob.held_conf_ack", Conf_ack, 0);
    @(negedge i_clk);
    #1;
    chk("rstjob.after_busy", o_busy, 0);
    chk("rstjob.after_wr", o_wp_write, 0);
    chk("rstjob.after_waddr", o_wp_waddr, 0);
    @(negedge i_clk);
    i_rst      = 1'b0;
    Weight_rdy = 1'b0;
    #1;
    chk("rstjob.idle_conf_ack", Conf_ack, 1);
    chk("rstjob.idle_busy", o_busy, 0);
    chk("rstjob.idle_waddr", o_wp_waddr, 0);
    run_job("restart", 0, 5, 0, 3, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
